inst_rom_loader: RTL

Byte-stream boot loader for the instruction memory. It receives a framed program image over an 8-bit valid/ready stream and assembles four-byte instruction words. Each word goes out on a write port into the instruction memory array, stored in the same word format the memh image files use. The loader holds the CPU in reset while loading, and reports done or error when the frame is complete.

---
 rtl/inst_rom_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/inst_rom_loader.sv
// Boot loader: takes a framed byte stream (length, data words, checksum) and
// writes assembled 32-bit words into instruction memory while holding the CPU.
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            acc_q, acc_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           word_q, word_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  accept;
    logic [15:0]           n_len;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            words_q   <= words_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        word_d    = word_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rx_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CSUM);
        accept    = rx_ready && rx_valid;
        n_len     = {rx_data, len_q[7:0]};

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LEN_LO;
                    acc_d   = '0;
                    idx_d   = '0;
                    words_d = '0;
                end
            end
            LEN_LO: if (accept) begin
                len_d   = {8'h00, rx_data};
                state_d = LEN_HI;
            end
            LEN_HI: if (accept) begin
                len_d = n_len;
                if (n_len == 16'd0 || {1'b0, n_len} > CAP) state_d = ERROR;
                else                                       state_d = DATA;
            end
            DATA: if (accept) begin
                acc_d  = acc_q + rx_data;
                idx_d  = idx_q + 2'd1;
                word_d = {word_q[15:0], rx_data};
                if (idx_q == 2'd3) begin
                    // First byte on the wire lands in the MSB (memh word order).
                    wr_en_d   = 1'b1;
                    wr_addr_d = words_q[ADDR_WIDTH-1:0];
                    wr_data_d = {word_q, rx_data};
                    words_d   = words_q + 1'b1;
                    if (16'(words_d) == len_q) state_d = CSUM;
                end
            end
            CSUM: if (accept) begin
                if (8'(acc_q + rx_data) == 8'h00) state_d = DONE;
                else                              state_d = ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = rx_ready;
    assign cpu_hold     = rx_ready || (state_q == ERROR);
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign words_loaded = words_q;

endmodule
